// File: rtl/sample_loader.sv
// sample_loader: packs a serial valid/ready byte stream into a flat
// little-endian sample bus, using two ping-pong banks so the next sample
// can load while the current one is being consumed.
module sample_loader #(
    parameter int unsigned NBYTES = 62,
    parameter int unsigned W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [NBYTES*W-1:0]  data_out,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic [1:0]           pending,
    output logic                 err_frame
);

    localparam int unsigned IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned BUSW = NBYTES * W;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    logic [BUSW-1:0] bank_a;
    logic [BUSW-1:0] bank_b;
    logic            full_a;
    logic            full_b;
    logic            wsel;
    logic            rsel;
    logic [IW-1:0]   widx;

    logic            full_a_nxt;
    logic            full_b_nxt;
    logic            wsel_nxt;
    logic            rsel_nxt;
    logic [IW-1:0]   widx_nxt;
    logic [1:0]      pending_nxt;
    logic            err_nxt;

    logic            accept;
    logic            at_last;
    logic            complete;
    logic            early_last;
    logic            ack;

    // Handshake and output muxing straight from registered bank state
    always_comb begin
        in_ready   = wsel ? !full_b : !full_a;
        data_valid = rsel ? full_b : full_a;
        data_out   = rsel ? bank_b : bank_a;
        accept     = in_valid && in_ready;
        at_last    = (widx == LAST_IDX);
        complete   = accept && at_last;
        early_last = accept && in_last && !at_last;
        ack        = data_ack && data_valid;
    end

    // Next-state for flags, selectors, byte index and error pulse.
    // A completing bank is never the bank being acked (one is empty, the
    // other full), so set and clear at the same edge never collide.
    always_comb begin
        full_a_nxt = full_a;
        full_b_nxt = full_b;
        wsel_nxt   = wsel;
        rsel_nxt   = rsel;
        widx_nxt   = widx;
        err_nxt    = 1'b0;

        if (complete) begin
            if (wsel) full_b_nxt = 1'b1;
            else      full_a_nxt = 1'b1;
            wsel_nxt = !wsel;
            widx_nxt = '0;
            err_nxt  = !in_last;
        end else if (early_last) begin
            widx_nxt = '0;
            err_nxt  = 1'b1;
        end else if (accept) begin
            widx_nxt = widx + IW'(1);
        end

        if (ack) begin
            if (rsel) full_b_nxt = 1'b0;
            else      full_a_nxt = 1'b0;
            rsel_nxt = !rsel;
        end

        pending_nxt = {1'b0, full_a_nxt} + {1'b0, full_b_nxt};
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_a    <= 1'b0;
            full_b    <= 1'b0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            widx      <= '0;
            pending   <= 2'd0;
            err_frame <= 1'b0;
        end else begin
            full_a    <= full_a_nxt;
            full_b    <= full_b_nxt;
            wsel      <= wsel_nxt;
            rsel      <= rsel_nxt;
            widx      <= widx_nxt;
            pending   <= pending_nxt;
            err_frame <= err_nxt;
        end
    end

    // Bank storage: accepted byte lands at its index in the write bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_a <= '0;
            bank_b <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (widx == IW'(i)) begin
                    if (wsel) bank_b[i*W +: W] <= in_data;
                    else      bank_a[i*W +: W] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_loader.sv
// Directed bench for sample_loader: a table of load/ack steps with expected
// outputs, plus hand-written sequences for latency, simultaneous
// ack/completion and mid-stream reset.
module tb_sample_loader;

    localparam int unsigned NB   = 62;
    localparam int unsigned BW   = 8;
    localparam int unsigned BUSW = NB * BW;

    logic            clk;
    logic            rst;
    logic [BW-1:0]   in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [BUSW-1:0] data_out;
    logic            data_valid;
    logic            data_ack;
    logic [1:0]      pending;
    logic            err_frame;

    int n_vec;
    int n_bad;
    int err_cnt;
    int err_base;

    sample_loader #(.NBYTES(NB), .W(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .pending    (pending),
        .err_frame  (err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count error pulses (bench-side event counter)
    initial err_cnt = 0;
    always @(negedge clk) if (rst && err_frame) err_cnt = err_cnt + 1;

    typedef struct {
        logic       is_ack;
        logic [7:0] fill;
        int         early_at;
        logic       final_last;
        logic       exp_valid;
        logic       exp_ready;
        logic [1:0] exp_pending;
        logic       chk_data;
        logic [7:0] exp_fill;
        int         exp_err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BUSW-1:0] exp);
        n_vec++;
        if (data_out !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, data_out, exp);
        end
    endtask

    function automatic logic [BUSW-1:0] fill_bus(input logic [7:0] f);
        logic [BUSW-1:0] b;
        for (int i = 0; i < NB; i++) b[i*8 +: 8] = f;
        return b;
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        data_ack = 1'b0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        err_base = err_cnt;
    endtask

    // Present one byte, wait (bounded) for in_ready, and complete transfer
    task automatic send_byte(input logic [7:0] d, input logic last, input logic ack);
        int waited;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        data_ack = ack;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        data_ack = 1'b0;
    endtask

    task automatic send_sample(input logic [7:0] fill, input int early_at, input logic final_last);
        for (int i = 0; i < NB; i++) begin
            send_byte(fill, (i == early_at) || (i == NB - 1 && final_last), 1'b0);
            if (i == early_at) break;
        end
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        data_ack = 1'b0;
    endtask

    initial begin
        logic [BUSW-1:0] inc_bus;
        n_vec    = 0;
        n_bad    = 0;
        err_base = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        data_ack = 1'b0;

        //           ack   fill   early fl  val  rdy  pend  cd   expf   err
        tbl[0]  = '{1'b0, 8'h11, -1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'h11, 0};
        tbl[1]  = '{1'b0, 8'h22, -1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 8'h11, 0};
        tbl[2]  = '{1'b1, 8'h00, -1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h22, 0};
        tbl[3]  = '{1'b0, 8'h33, -1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 8'h22, 0};
        tbl[4]  = '{1'b1, 8'h00, -1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h33, 0};
        tbl[5]  = '{1'b1, 8'h00, -1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 0};
        tbl[6]  = '{1'b1, 8'h00, -1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 0};
        tbl[7]  = '{1'b0, 8'hEE,  9, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 1};
        tbl[8]  = '{1'b0, 8'hA5, -1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'hA5, 1};
        tbl[9]  = '{1'b0, 8'h5A, -1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 8'hA5, 2};
        tbl[10] = '{1'b1, 8'h00, -1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h5A, 2};
        tbl[11] = '{1'b1, 8'h00, -1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 2};

        // Reset values and single incrementing sample with latency check
        do_reset();
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_err", 64'(err_frame), 64'd0);
        chk_bus("rst_data", '0);
        for (int i = 0; i < NB - 1; i++) send_byte(8'(i), 1'b0, 1'b0);
        chk("single_valid_before_last", 64'(data_valid), 64'd0);
        send_byte(8'(NB - 1), 1'b1, 1'b0);
        chk("single_valid_latency", 64'(data_valid), 64'd1);
        for (int i = 0; i < NB; i++) inc_bus[i*8 +: 8] = 8'(i);
        chk_bus("single_data", inc_bus);
        chk("single_pending", 64'(pending), 64'd1);
        @(posedge clk);
        #1;
        chk("single_err_count", 64'(err_cnt - err_base), 64'd0);

        // Table-driven ping-pong, backpressure, framing errors, spurious ack
        do_reset();
        for (int v = 0; v < 12; v++) begin
            if (tbl[v].is_ack) pulse_ack();
            else send_sample(tbl[v].fill, tbl[v].early_at, tbl[v].final_last);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", v), 64'(data_valid), 64'(tbl[v].exp_valid));
            chk($sformatf("v%0d_ready", v), 64'(in_ready), 64'(tbl[v].exp_ready));
            chk($sformatf("v%0d_pending", v), 64'(pending), 64'(tbl[v].exp_pending));
            chk($sformatf("v%0d_err_count", v), 64'(err_cnt - err_base), 64'(tbl[v].exp_err));
            chk($sformatf("v%0d_err_idle", v), 64'(err_frame), 64'd0);
            if (tbl[v].chk_data) chk_bus($sformatf("v%0d_data", v), fill_bus(tbl[v].exp_fill));
        end

        // Ack in the same cycle that the other bank completes
        do_reset();
        send_sample(8'h11, -1, 1'b1);
        for (int i = 0; i < NB - 1; i++) send_byte(8'h77, 1'b0, 1'b0);
        send_byte(8'h77, 1'b1, 1'b1);
        chk("simul_valid", 64'(data_valid), 64'd1);
        chk("simul_pending", 64'(pending), 64'd1);
        chk("simul_ready", 64'(in_ready), 64'd1);
        chk_bus("simul_data", fill_bus(8'h77));

        // Reset mid-stream with one bank full, then a fresh load
        do_reset();
        send_sample(8'h44, -1, 1'b1);
        for (int i = 0; i < 30; i++) send_byte(8'h66, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(data_valid), 64'd0);
        chk("midrst_pending", 64'(pending), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk_bus("midrst_data", '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        err_base = err_cnt;
        send_sample(8'h3C, -1, 1'b1);
        chk("fresh_valid", 64'(data_valid), 64'd1);
        chk("fresh_pending", 64'(pending), 64'd1);
        chk_bus("fresh_data", fill_bus(8'h3C));
        pulse_ack();
        chk("fresh_ack_valid", 64'(data_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
